// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Step-counter stimulus source. Emits one-cycle step pulses at a
//   mode-selected rate, with exactly R pulses in every CLK_HZ-cycle window.
//   It also keeps a seconds timebase for the display path.
//   The pulses are spread over each window by a phase accumulator, so no
//   divider is needed.
// Ports
//   clk        system clock, all state on posedge
//   reset      synchronous active-high clear (wins over start)
//   start      1 = generate, 0 = idle with all state cleared
//   mode       00 walk 32/s, 01 jog 64/s, 10 run 128/s, 11 hybrid table
//   stepPulse  registered one-cycle step pulse
//   secTick    one-cycle pulse the cycle after each window completes
//   elapsedSec completed windows since start, saturating
//   rateNow    steps/s applied in the current window
module step_pulse_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int SEC_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic             stepPulse,
  output logic             secTick,
  output logic [SEC_W-1:0] elapsedSec,
  output logic [7:0]       rateNow
);

  // acc < CLK_HZ always, so acc+rate never exceeds CLK_HZ+255
  localparam int ACC_W = $clog2(CLK_HZ + 256);
  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [ACC_W-1:0] HZ   = ACC_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, stateNxt;
  logic [CNT_W-1:0] cycCnt, cycCntNxt;
  logic [ACC_W-1:0] acc, accNxt, sum;
  logic [3:0]       hybIdx, hybIdxNxt;
  logic [1:0]       winMode, winModeNxt;  // mode that selected the current window
  logic [7:0]       rateEff, rateNowNxt;
  logic [SEC_W-1:0] secNxt;
  logic             stepNxt, tickNxt, wrap;

  function automatic logic [7:0] hybRate(input logic [3:0] idx);
    case (idx)
      4'd0:    hybRate = 8'd20;
      4'd1:    hybRate = 8'd33;
      4'd2:    hybRate = 8'd66;
      4'd3:    hybRate = 8'd27;
      4'd4:    hybRate = 8'd70;
      4'd5:    hybRate = 8'd30;
      4'd6:    hybRate = 8'd19;
      4'd7:    hybRate = 8'd30;
      4'd8:    hybRate = 8'd33;
      default: hybRate = 8'd0;   // hybrid run exhausted
    endcase
  endfunction

  function automatic logic [7:0] modeRate(input logic [1:0] m, input logic [3:0] idx);
    case (m)
      2'b00:   modeRate = 8'd32;
      2'b01:   modeRate = 8'd64;
      2'b10:   modeRate = 8'd128;
      default: modeRate = hybRate(idx);
    endcase
  endfunction

  always_comb begin
    stateNxt   = state;
    cycCntNxt  = cycCnt;
    accNxt     = acc;
    hybIdxNxt  = hybIdx;
    winModeNxt = winMode;
    rateNowNxt = rateNow;
    secNxt     = elapsedSec;
    stepNxt    = 1'b0;
    tickNxt    = 1'b0;
    rateEff    = rateNow;
    sum        = '0;
    wrap       = 1'b0;
    if (!start) begin
      stateNxt   = IDLE;
      cycCntNxt  = '0;
      accNxt     = '0;
      hybIdxNxt  = '0;
      winModeNxt = 2'b00;
      rateNowNxt = '0;
      secNxt     = '0;
    end else begin
      stateNxt = RUN;
      // First active cycle: the freshly selected rate already counts for
      // cycle 0, so the window still holds exactly R pulses.
      if (state == IDLE) begin
        rateEff    = modeRate(mode, 4'd0);
        rateNowNxt = rateEff;
        winModeNxt = mode;
        hybIdxNxt  = '0;
      end
      sum = acc + ACC_W'(rateEff);
      if (sum >= HZ) begin
        stepNxt = 1'b1;
        accNxt  = sum - HZ;
      end else begin
        accNxt  = sum;
      end
      wrap = (cycCnt == LAST);
      if (wrap) begin
        // The compare above still fires the last pulse of the window.
        cycCntNxt = '0;
        accNxt    = '0;
        tickNxt   = 1'b1;
        if (elapsedSec != '1) secNxt = elapsedSec + SEC_W'(1);
        // Hybrid index only advances while hybrid persists across windows.
        if (mode == 2'b11 && winMode == 2'b11)
          hybIdxNxt = (hybIdx == 4'd9) ? 4'd9 : hybIdx + 4'd1;
        else
          hybIdxNxt = '0;
        winModeNxt = mode;
        rateNowNxt = modeRate(mode, hybIdxNxt);
      end else begin
        cycCntNxt = cycCnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cycCnt     <= '0;
      acc        <= '0;
      hybIdx     <= '0;
      winMode    <= 2'b00;
      rateNow    <= '0;
      elapsedSec <= '0;
      stepPulse  <= 1'b0;
      secTick    <= 1'b0;
    end else begin
      state      <= stateNxt;
      cycCnt     <= cycCntNxt;
      acc        <= accNxt;
      hybIdx     <= hybIdxNxt;
      winMode    <= winModeNxt;
      rateNow    <= rateNowNxt;
      elapsedSec <= secNxt;
      stepPulse  <= stepNxt;
      secTick    <= tickNxt;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen.
// It drives two instances from the same inputs: one with SEC_W=16 and one
// with SEC_W=2, which is used for the saturation check. Each cycle the
// reference model pushes the expected outputs into a queue. A monitor pops
// one entry per cycle and compares it with both instances.
// The model places pulses by integer division instead of an accumulator.
// After window-local active cycle k at rate R, a pulse is expected when
// floor((k+1)R/HZ) differs from floor(kR/HZ).
module tb_step_pulse_gen;
  localparam int HZ = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic stepA, tickA, stepB, tickB;
  logic [15:0] secA;
  logic [1:0]  secB;
  logic [7:0]  rateA, rateB;

  always #5 clk = ~clk;

  step_pulse_gen #(.CLK_HZ(HZ), .SEC_W(16)) dutA (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .stepPulse(stepA), .secTick(tickA), .elapsedSec(secA), .rateNow(rateA));

  step_pulse_gen #(.CLK_HZ(HZ), .SEC_W(2)) dutB (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .stepPulse(stepB), .secTick(tickB), .elapsedSec(secB), .rateNow(rateB));

  typedef struct {
    logic        step;
    logic        tick;
    logic [15:0] sec;
    logic [1:0]  sec2;
    logic [7:0]  rate;
    int          idx;
  } exp_t;

  exp_t q[$];
  int nChecks = 0, nFail = 0;
  int phaseCnt = 0, dutPulses = 0, firstPulse = -1;
  int hybTab[10] = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 0};

  // reference model state
  bit   mActive = 0;
  int   mK = 0, mR = 0, mIdx = 0, mSec = 0;
  logic [1:0] mWin = 2'b00;

  function automatic int rateOf(input logic [1:0] m, input int idx);
    case (m)
      2'b00:   return 32;
      2'b01:   return 64;
      2'b10:   return 128;
      default: return hybTab[idx];
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus plus the expected outputs after that edge
  task automatic cyc(input logic r, input logic s, input logic [1:0] m);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; mode = m;
    e.idx = phaseCnt;
    phaseCnt++;
    if (r || !s) begin
      mActive = 0; mK = 0; mSec = 0; mR = 0;
      e.step = 0; e.tick = 0; e.rate = 0;
    end else begin
      if (!mActive) begin
        mActive = 1; mK = 0; mIdx = 0; mWin = m; mR = rateOf(m, 0);
      end
      e.step = (((mK + 1) * mR) / HZ) != ((mK * mR) / HZ);
      if (mK == HZ - 1) begin
        e.tick = 1;
        mSec++;
        if (m == 2'b11 && mWin == 2'b11) mIdx = (mIdx >= 9) ? 9 : mIdx + 1;
        else mIdx = 0;
        mWin = m;
        mR = rateOf(m, mIdx);
        mK = 0;
      end else begin
        e.tick = 0;
        mK++;
      end
      e.rate = 8'(mR);
    end
    e.sec  = (mSec > 65535) ? 16'hFFFF : 16'(mSec);
    e.sec2 = (mSec > 3) ? 2'd3 : 2'(mSec);
    q.push_back(e);
  endtask

  task automatic run(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, m);
  endtask

  task automatic newPhase();
    phaseCnt = 0; dutPulses = 0; firstPulse = -1;
  endtask

  // Settle to just after the monitor has sampled the last edge
  task automatic settle();
    @(posedge clk); #2;
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        nChecks++;
        if (stepA !== e.step || tickA !== e.tick || secA !== e.sec || rateA !== e.rate ||
            stepB !== e.step || tickB !== e.tick || secB !== e.sec2 || rateB !== e.rate) begin
          nFail++;
          $display("FAIL cycle %0d outputs: got step=%b/%b tick=%b/%b sec=%0d/%0d rate=%0d/%0d expected step=%b tick=%b sec=%0d/%0d rate=%0d",
                   e.idx, stepA, stepB, tickA, tickB, secA, secB, rateA, rateB,
                   e.step, e.tick, e.sec, e.sec2, e.rate);
        end
        if (stepA === 1'b1) begin
          if (firstPulse < 0) firstPulse = e.idx;
          dutPulses++;
        end
      end
    end
  end

  initial begin
    logic s;
    logic [1:0] m;
    // reset state
    cyc(1'b1, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 2'b10);
    settle();
    chk("reset_step", int'(stepA), 0);
    chk("reset_rate", int'(rateA), 0);

    // 1 walk: 3 windows
    newPhase();
    run(3000, 2'b00);
    settle();
    chk("walk_pulses", dutPulses, 96);
    chk("walk_sec", int'(secA), 3);
    chk("walk_rate", int'(rateA), 32);

    // 2 run: first pulse registered on active cycle 7, visible in cycle 8
    cyc(1'b0, 1'b0, 2'b00);
    newPhase();
    run(1000, 2'b10);
    settle();
    chk("run_pulses", dutPulses, 128);
    chk("run_first_pulse_edge", firstPulse, 7);

    // 3 hybrid: 11 windows
    cyc(1'b0, 1'b0, 2'b00);
    newPhase();
    run(11000, 2'b11);
    settle();
    chk("hyb_pulses", dutPulses, 328);
    chk("hyb_sec", int'(secA), 11);
    chk("hyb_rate_end", int'(rateA), 0);

    // 4 mid-window switch walk -> jog
    cyc(1'b0, 1'b0, 2'b00);
    newPhase();
    run(500, 2'b00);
    run(500, 2'b01);
    settle();
    chk("switch_win1", dutPulses, 32);
    newPhase();
    run(1000, 2'b01);
    settle();
    chk("switch_win2", dutPulses, 64);

    // 5 start drop at cycle 700 of window 2, then re-raise in hybrid
    cyc(1'b0, 1'b0, 2'b00);
    run(1700, 2'b11);
    cyc(1'b0, 1'b0, 2'b11);
    settle();
    chk("drop_sec", int'(secA), 0);
    chk("drop_rate", int'(rateA), 0);
    chk("drop_tick", int'(tickA), 0);
    newPhase();
    run(1000, 2'b11);
    settle();
    chk("reraise_pulses", dutPulses, 20);
    chk("reraise_sec", int'(secA), 1);

    // 6 reset mid-run with start held, then saturation of the 2-bit counter
    run(1500, 2'b00);
    cyc(1'b1, 1'b1, 2'b00);
    cyc(1'b1, 1'b1, 2'b00);
    settle();
    chk("rst_sec", int'(secA), 0);
    chk("rst_rate", int'(rateA), 0);
    newPhase();
    run(5000, 2'b00);
    settle();
    chk("sat_pulses", dutPulses, 160);
    chk("sat_secA", int'(secA), 5);
    chk("sat_secB", int'(secB), 3);

    // random phase
    s = 1'b1;
    m = 2'(($urandom_range(0, 3)));
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 1499) == 0) s = ~s;
      if ($urandom_range(0, 699) == 0) m = 2'($urandom_range(0, 3));
      cyc(($urandom_range(0, 1999) == 0), s, m);
    end

    cyc(1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 2'b00);
    settle();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
